prio_encoder_rr: RTL and testbench

Parametrised, registered N-to-log2(N) priority encoder with a valid/ready handshake on both sides. It supports two modes: fixed priority (highest index wins) and round-robin (a rotating pointer). It accepts one request vector per cycle, registers the encoded index, flags multi-hot inputs and counts all-zero vectors. It replaces the combinational 8-to-3 OR encoder wherever arbitration, back-pressure or illegal-input detection is needed.

---
 rtl/prio_encoder_rr.sv | 114 +++++++++++
 tb/tb_prio_encoder_rr.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_encoder_rr.sv
// Registered N-to-W priority encoder with valid/ready on both sides.
// RR=0 grants the highest set index; RR=1 grants the first set index at or after a rotating pointer.
module prio_encoder_rr #(
  parameter int N  = 8,
  parameter int W  = 3,
  parameter int RR = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         req_valid,
  output logic         req_ready,
  output logic [W-1:0] idx,
  output logic         multi,
  output logic         idx_valid,
  input  logic         idx_ready,
  output logic [7:0]   zero_cnt,
  output logic [W-1:0] ptr
);

  localparam logic [W:0] N_EXT = (W+1)'(N);

  // A vector is multi-hot when clearing its lowest set bit leaves something behind.
  function automatic logic multi_hot(input logic [N-1:0] v);
    return (v & (v - N'(1'b1))) != '0;
  endfunction

  logic [W-1:0]   idx_r;
  logic           multi_r;
  logic           idx_valid_r;
  logic [7:0]     zero_cnt_r;
  logic [W-1:0]   ptr_r;

  logic           req_ready_s;
  logic           accept_s;
  logic           consume_s;
  logic           nonzero_s;
  logic [2*N-1:0] dbl_s;
  logic [N-1:0]   rot_s;
  logic [W-1:0]   fixed_sel_s;
  logic [W-1:0]   rr_off_s;
  logic [W:0]     rr_sum_s;
  logic [W-1:0]   rr_sel_s;
  logic [W-1:0]   sel_s;
  logic [W-1:0]   next_ptr_s;

  assign req_ready_s = !idx_valid_r || idx_ready;
  assign accept_s    = req_valid && req_ready_s;
  assign consume_s   = idx_valid_r && idx_ready;
  assign nonzero_s   = |req;

  // Fixed priority: ascending scan, so the highest set bit is the last one to stick.
  always_comb begin
    fixed_sel_s = '0;
    for (int k = 0; k < N; k++) begin
      if (req[k]) fixed_sel_s = W'(k);
      else        fixed_sel_s = fixed_sel_s;
    end
  end

  // Round-robin: rotate ptr down to bit 0, pick the lowest set bit, then undo the rotation mod N.
  always_comb begin
    dbl_s    = {req, req};
    rot_s    = N'(dbl_s >> ptr_r);
    rr_off_s = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot_s[k]) rr_off_s = W'(k);
      else          rr_off_s = rr_off_s;
    end
    rr_sum_s = {1'b0, ptr_r} + {1'b0, rr_off_s};
    if (rr_sum_s >= N_EXT) rr_sel_s = W'(rr_sum_s - N_EXT);
    else                   rr_sel_s = rr_sum_s[W-1:0];
  end

  // Mode select and the pointer value that follows a grant.
  always_comb begin
    if (RR != 0) sel_s = rr_sel_s;
    else         sel_s = fixed_sel_s;
    if (sel_s == W'(N - 1)) next_ptr_s = '0;
    else                    next_ptr_s = sel_s + W'(1'b1);
  end

  // One-entry result register, pointer and saturating zero counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r       <= '0;
      multi_r     <= 1'b0;
      idx_valid_r <= 1'b0;
      zero_cnt_r  <= 8'd0;
      ptr_r       <= '0;
    end else begin
      if (accept_s && nonzero_s) begin
        idx_r       <= sel_s;
        multi_r     <= multi_hot(req);
        idx_valid_r <= 1'b1;
        if (RR != 0) ptr_r <= next_ptr_s;
        else         ptr_r <= '0;
      end else if (consume_s) begin
        idx_valid_r <= 1'b0;
      end
      if (accept_s && !nonzero_s && (zero_cnt_r != 8'hFF)) begin
        zero_cnt_r <= zero_cnt_r + 8'd1;
      end
    end
  end

  assign req_ready = req_ready_s;
  assign idx       = idx_r;
  assign multi     = multi_r;
  assign idx_valid = idx_valid_r;
  assign zero_cnt  = zero_cnt_r;
  assign ptr       = ptr_r;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Drives a fixed-priority and a round-robin instance with shared stimulus and
// compares both against a behavioural model every cycle, plus literal spot checks.
module tb_prio_encoder_rr;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic         req_valid;
  logic         idx_ready;

  logic         rdy_s  [2];
  logic [W-1:0] idx_s  [2];
  logic         mul_s  [2];
  logic         vld_s  [2];
  logic [7:0]   zc_s   [2];
  logic [W-1:0] ptr_s  [2];

  logic         mv_a [2];
  logic         mm_a [2];
  int           mi_a [2];
  int           mz_a [2];
  int           mp_a [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  initial begin
    if ((32'd1 << W) < N) begin
      $display("FAIL param_check: W=%0d too small for N=%0d", W, N);
      $fatal(1);
    end
  end

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, d, act, exp, $time);
    end
  endtask

  // Highest set index.
  function automatic int hi_idx(input logic [N-1:0] v);
    for (int k = N - 1; k >= 0; k--) if (v[W'(k)]) return k;
    return 0;
  endfunction

  // First set index scanning p, p+1, ... wrapping at N.
  function automatic int rr_idx(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) if (v[W'((p + i) % N)]) return (p + i) % N;
    return 0;
  endfunction

  for (genvar d = 0; d < 2; d++) begin : g_inst
    prio_encoder_rr #(.N(N), .W(W), .RR(d)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_valid (req_valid),
      .req_ready (rdy_s[d]),
      .idx       (idx_s[d]),
      .multi     (mul_s[d]),
      .idx_valid (vld_s[d]),
      .idx_ready (idx_ready),
      .zero_cnt  (zc_s[d]),
      .ptr       (ptr_s[d])
    );

    logic m_valid;
    logic m_multi;
    int   m_idx;
    int   m_zc;
    int   m_ptr;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_valid <= 1'b0;
        m_multi <= 1'b0;
        m_idx   <= 0;
        m_zc    <= 0;
        m_ptr   <= 0;
      end else if (req_valid && (!m_valid || idx_ready)) begin
        if (req != '0) begin
          m_idx   <= (d == 0) ? hi_idx(req) : rr_idx(req, m_ptr);
          m_multi <= ($countones(req) > 1);
          m_valid <= 1'b1;
          if (d == 1) m_ptr <= (rr_idx(req, m_ptr) + 1) % N;
        end else begin
          if (m_zc < 255) m_zc <= m_zc + 1;
          if (m_valid) m_valid <= 1'b0;
        end
      end else if (m_valid && idx_ready) begin
        m_valid <= 1'b0;
      end
    end

    assign mv_a[d] = m_valid;
    assign mm_a[d] = m_multi;
    assign mi_a[d] = m_idx;
    assign mz_a[d] = m_zc;
    assign mp_a[d] = m_ptr;
  end

  // Every falling edge outside reset: both instances against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        chk("req_ready", d, 32'(rdy_s[d]), 32'(!mv_a[d] || idx_ready));
        chk("idx_valid", d, 32'(vld_s[d]), 32'(mv_a[d]));
        chk("idx",       d, 32'(idx_s[d]), 32'(mi_a[d]));
        chk("multi",     d, 32'(mul_s[d]), 32'(mm_a[d]));
        chk("zero_cnt",  d, 32'(zc_s[d]),  32'(mz_a[d]));
        chk("ptr",       d, 32'(ptr_s[d]), 32'(mp_a[d]));
      end
    end
  end

  task automatic cyc(input logic [N-1:0] r, input logic rv, input logic ir);
    req       = r;
    req_valid = rv;
    idx_ready = ir;
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b1;
    req       = '0;
    req_valid = 1'b0;
    idx_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_idx_valid", d, 32'(vld_s[d]), 32'd0);
      chk("rst_idx",       d, 32'(idx_s[d]), 32'd0);
      chk("rst_multi",     d, 32'(mul_s[d]), 32'd0);
      chk("rst_zero_cnt",  d, 32'(zc_s[d]),  32'd0);
      chk("rst_ptr",       d, 32'(ptr_s[d]), 32'd0);
      chk("rst_req_ready", d, 32'(rdy_s[d]), 32'd1);
    end
    rst_n = 1'b1;

    // Round-robin fairness between bits 0 and 7.
    for (int i = 0; i < 4; i++) begin
      cyc(8'h81, 1'b1, 1'b1);
      chk("rr_fair_idx", 1, 32'(idx_s[1]), (i % 2 == 0) ? 32'd0 : 32'd7);
      chk("rr_fair_ptr", 1, 32'(ptr_s[1]), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("fix_81_idx",  0, 32'(idx_s[0]), 32'd7);
    end
    cyc(8'h10, 1'b1, 1'b1);
    chk("rr_10_idx", 1, 32'(idx_s[1]), 32'd4);
    chk("rr_10_ptr", 1, 32'(ptr_s[1]), 32'd5);

    // Single-hot sweep at full throughput.
    for (int i = 0; i < N; i++) begin
      cyc(8'(32'd1 << i), 1'b1, 1'b1);
      chk("sweep_idx",   0, 32'(idx_s[0]), 32'(i));
      chk("sweep_multi", 0, 32'(mul_s[0]), 32'd0);
      chk("sweep_valid", 0, 32'(vld_s[0]), 32'd1);
    end

    cyc(8'h15, 1'b1, 1'b1);
    chk("mh15_idx",   0, 32'(idx_s[0]), 32'd4);
    chk("mh15_multi", 0, 32'(mul_s[0]), 32'd1);
    cyc(8'hFF, 1'b1, 1'b1);
    chk("mhFF_idx",   0, 32'(idx_s[0]), 32'd7);
    chk("mhFF_multi", 0, 32'(mul_s[0]), 32'd1);

    // Back-pressure: result held, input blocked until idx_ready returns.
    cyc(8'h08, 1'b1, 1'b1);
    chk("bp_first_idx", 0, 32'(idx_s[0]), 32'd3);
    for (int i = 0; i < 3; i++) begin
      cyc(8'h40, 1'b1, 1'b0);
      chk("bp_req_ready", 0, 32'(rdy_s[0]), 32'd0);
      chk("bp_idx_hold",  0, 32'(idx_s[0]), 32'd3);
    end
    cyc(8'h40, 1'b1, 1'b1);
    chk("bp_release_idx", 0, 32'(idx_s[0]), 32'd6);
    chk("bp_release_vld", 0, 32'(vld_s[0]), 32'd1);

    cyc(8'h00, 1'b0, 1'b1);
    chk("drain_valid", 0, 32'(vld_s[0]), 32'd0);

    // Zero vectors saturate the counter.
    for (int i = 0; i < 300; i++) begin
      cyc(8'h00, 1'b1, 1'b1);
      chk("zero_valid", 0, 32'(vld_s[0]), 32'd0);
      if (i == 253) chk("zero_cnt_254", 0, 32'(zc_s[0]), 32'd254);
    end
    chk("zero_sat", 0, 32'(zc_s[0]), 32'd255);
    chk("zero_sat", 1, 32'(zc_s[1]), 32'd255);
    cyc(8'h02, 1'b1, 1'b1);
    chk("zero_then_idx", 0, 32'(idx_s[0]), 32'd1);
    chk("zero_then_cnt", 0, 32'(zc_s[0]),  32'd255);

    // Random traffic against the model.
    pulse_reset();
    for (int i = 0; i < 500; i++) begin
      logic [N-1:0] r;
      case ($urandom_range(0, 3))
        0:       r = '0;
        1:       r = 8'(32'd1 << $urandom_range(0, N - 1));
        default: r = 8'($urandom);
      endcase
      cyc(r, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end

    // Asynchronous reset between edges with a pending result.
    pulse_reset();
    repeat (9) cyc(8'h00, 1'b1, 1'b1);
    cyc(8'h10, 1'b1, 1'b0);
    chk("pre_rst_valid", 1, 32'(vld_s[1]), 32'd1);
    chk("pre_rst_ptr",   1, 32'(ptr_s[1]), 32'd5);
    chk("pre_rst_zc",    1, 32'(zc_s[1]),  32'd9);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("arst_idx_valid", d, 32'(vld_s[d]), 32'd0);
      chk("arst_ptr",       d, 32'(ptr_s[d]), 32'd0);
      chk("arst_zero_cnt",  d, 32'(zc_s[d]),  32'd0);
      chk("arst_idx",       d, 32'(idx_s[d]), 32'd0);
      chk("arst_req_ready", d, 32'(rdy_s[d]), 32'd1);
    end
    @(negedge clk);
    #1 rst_n = 1'b1;
    cyc(8'h24, 1'b1, 1'b1);
    chk("post_rst_fix", 0, 32'(idx_s[0]), 32'd5);
    chk("post_rst_rr",  1, 32'(idx_s[1]), 32'd2);
    cyc(8'h00, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
